// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached burst RAM: command opcodes carried
// in the top two bits of every command word.
package spi_ram_pkg;

   typedef logic [1:0] opcode_t;

   localparam opcode_t OP_SET_WADDR = 2'b00;
   localparam opcode_t OP_WRITE     = 2'b01;
   localparam opcode_t OP_SET_RADDR = 2'b10;
   localparam opcode_t OP_READ      = 2'b11;

endpackage

// File: rtl/sp_ram_array.sv
// Single-port word RAM with a registered read port; rdata holds its value
// until the next read. Contents are never reset.
module sp_ram_array #(
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [ADDR_WIDTH-1:0] wdata,
   input  logic                  re,
   output logic [ADDR_WIDTH-1:0] rdata
);

   logic [ADDR_WIDTH-1:0] mem [MEM_DEPTH];
   logic [ADDR_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder in front of a single-port RAM: write/read pointers with
// optional wrapping auto-increment and a valid/ready read-return slot.
module spi_ram_burst
   import spi_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH+1:0] din,
   input  logic                  rx_valid,
   input  logic                  burst_en,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] dout,
   output logic                  tx_valid,
   output logic                  rd_err,
   output logic                  addr_err
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   opcode_t               op;
   logic [ADDR_WIDTH-1:0] payload;
   logic                  payload_ok;
   logic                  slot_free;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  rd_err_q, rd_err_d;
   logic                  addr_err_q, addr_err_d;
   logic                  dout_live_q, dout_live_d;

   logic                  mem_we;
   logic                  mem_re;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [ADDR_WIDTH-1:0] mem_rdata;

   assign op         = opcode_t'(din[ADDR_WIDTH+1:ADDR_WIDTH]);
   assign payload    = din[ADDR_WIDTH-1:0];
   assign payload_ok = {1'b0, payload} < DEPTH_EXT;
   assign slot_free  = !tx_valid_q || tx_ready;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      tx_valid_d  = tx_valid_q;
      rd_err_d    = 1'b0;
      addr_err_d  = 1'b0;
      dout_live_d = dout_live_q;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_addr    = wr_ptr_q;

      if (tx_valid_q && tx_ready) begin
         tx_valid_d = 1'b0;
      end

      if (rx_valid) begin
         case (op)
            OP_SET_WADDR: begin
               if (payload_ok) wr_ptr_d = payload;
               else            addr_err_d = 1'b1;
            end
            OP_WRITE: begin
               mem_we = rst_n;
               if (burst_en) wr_ptr_d = next_ptr(wr_ptr_q);
            end
            OP_SET_RADDR: begin
               if (payload_ok) rd_ptr_d = payload;
               else            addr_err_d = 1'b1;
            end
            default: begin
               // A read either refills the slot (possibly back-to-back with a
               // handshake) or is dropped with an error pulse.
               if (slot_free) begin
                  mem_re      = 1'b1;
                  mem_addr    = rd_ptr_q;
                  tx_valid_d  = 1'b1;
                  dout_live_d = 1'b1;
                  if (burst_en) rd_ptr_d = next_ptr(rd_ptr_q);
               end else begin
                  rd_err_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tx_valid_q  <= 1'b0;
         rd_err_q    <= 1'b0;
         addr_err_q  <= 1'b0;
         dout_live_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         tx_valid_q  <= tx_valid_d;
         rd_err_q    <= rd_err_d;
         addr_err_q  <= addr_err_d;
         dout_live_q <= dout_live_d;
      end
   end

   sp_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (payload),
      .re    (mem_re),
      .rdata (mem_rdata)
   );

   // The RAM output is not resettable, so dout is forced to zero until the
   // first read after reset has loaded it.
   assign dout     = dout_live_q ? mem_rdata : '0;
   assign tx_valid = tx_valid_q;
   assign rd_err   = rd_err_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst with a non-power-of-two depth; a
// cycle model feeds a scoreboard queue of expected read-return words.
module tb_spi_ram_burst;

   localparam int AW    = 8;
   localparam int DEPTH = 200;

   localparam logic [1:0] SW = 2'b00;
   localparam logic [1:0] WR = 2'b01;
   localparam logic [1:0] SR = 2'b10;
   localparam logic [1:0] RD = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW+1:0] din;
   logic          rx_valid;
   logic          burst_en;
   logic          tx_ready;
   logic [AW-1:0] dout;
   logic          tx_valid;
   logic          rd_err;
   logic          addr_err;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] m_mem [256];
   logic [AW-1:0] m_wp, m_rp, m_last;
   logic          m_tv;
   logic [AW-1:0] sb_q [$];

   spi_ram_burst #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .rx_valid (rx_valid),
      .burst_en (burst_en),
      .tx_ready (tx_ready),
      .dout     (dout),
      .tx_valid (tx_valid),
      .rd_err   (rd_err),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] wrapInc(input logic [AW-1:0] p);
      return (int'(p) + 1 >= DEPTH) ? '0 : p + 1'b1;
   endfunction

   task automatic modelReset();
      m_wp   = '0;
      m_rp   = '0;
      m_last = '0;
      m_tv   = 1'b0;
      sb_q.delete();
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [AW-1:0] pl,
                                input logic b, input logic rdy);
      logic exp_rd_err, exp_addr_err, slot_free, accepted;
      rx_valid = v;
      din      = {op, pl};
      burst_en = b;
      tx_ready = rdy;

      exp_rd_err   = 1'b0;
      exp_addr_err = 1'b0;
      accepted     = 1'b0;
      slot_free    = !m_tv || rdy;
      if (m_tv && rdy) begin
         m_last = sb_q.pop_front();
      end
      if (v) begin
         case (op)
            SW: if (int'(pl) < DEPTH) m_wp = pl; else exp_addr_err = 1'b1;
            WR: begin
               m_mem[m_wp] = pl;
               if (b) m_wp = wrapInc(m_wp);
            end
            SR: if (int'(pl) < DEPTH) m_rp = pl; else exp_addr_err = 1'b1;
            default: begin
               if (slot_free) begin
                  sb_q.push_back(m_mem[m_rp]);
                  accepted = 1'b1;
                  if (b) m_rp = wrapInc(m_rp);
               end else begin
                  exp_rd_err = 1'b1;
               end
            end
         endcase
      end
      if (accepted)          m_tv = 1'b1;
      else if (m_tv && rdy)  m_tv = 1'b0;

      @(posedge clk);
      #1;
      checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, m_tv});
      checkOutput("rd_err",   {31'b0, rd_err},   {31'b0, exp_rd_err});
      checkOutput("addr_err", {31'b0, addr_err}, {31'b0, exp_addr_err});
      if (m_tv && sb_q.size() > 0) begin
         if (!$isunknown(sb_q[0])) checkOutput("dout_valid", {24'b0, dout}, {24'b0, sb_q[0]});
      end else if (!$isunknown(m_last)) begin
         checkOutput("dout_hold", {24'b0, dout}, {24'b0, m_last});
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 'x;
      modelReset();
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      din      = '0;
      burst_en = 1'b0;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      checkOutput("rst_dout",     {24'b0, dout},     32'd0);
      checkOutput("rst_rd_err",   {31'b0, rd_err},   32'd0);
      checkOutput("rst_addr_err", {31'b0, addr_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single write and read with immediate acceptance
      applyStimulus(1, SW, 8'h05, 0, 1);
      applyStimulus(1, WR, 8'hA5, 0, 1);
      applyStimulus(1, SR, 8'h05, 0, 1);
      applyStimulus(1, RD, 8'h00, 0, 1);
      checkOutput("basic_dout", {24'b0, dout}, 32'h0000_00A5);
      applyStimulus(0, SW, 8'h00, 0, 1);

      // Burst across the wrap point at DEPTH-1
      applyStimulus(1, SW, 8'hC6, 0, 1);
      applyStimulus(1, WR, 8'h11, 1, 1);
      applyStimulus(1, WR, 8'h22, 1, 1);
      applyStimulus(1, WR, 8'h33, 1, 1);
      applyStimulus(1, SR, 8'hC6, 0, 1);
      applyStimulus(1, RD, 8'h00, 1, 1);
      applyStimulus(1, RD, 8'h00, 1, 1);
      applyStimulus(1, RD, 8'h00, 1, 1);
      checkOutput("wrap_dout", {24'b0, dout}, 32'h0000_0033);
      applyStimulus(0, SW, 8'h00, 0, 1);
      applyStimulus(1, WR, 8'h44, 0, 1);
      applyStimulus(1, RD, 8'h00, 0, 1);
      checkOutput("wrap_ptrs", {24'b0, dout}, 32'h0000_0044);
      applyStimulus(0, SW, 8'h00, 0, 1);

      // Out-of-range set-address commands
      applyStimulus(1, SW, 8'hC8, 0, 1);
      applyStimulus(1, SR, 8'hFF, 0, 1);
      applyStimulus(1, WR, 8'h55, 0, 1);
      applyStimulus(1, RD, 8'h00, 0, 1);
      applyStimulus(0, SW, 8'h00, 0, 1);

      // Backpressure, dropped read, then back-to-back refill
      applyStimulus(1, SR, 8'hC6, 0, 0);
      applyStimulus(1, RD, 8'h00, 1, 0);
      applyStimulus(1, RD, 8'h00, 1, 0);
      applyStimulus(0, RD, 8'h00, 1, 0);
      applyStimulus(1, RD, 8'h00, 1, 1);
      checkOutput("bp_next", {24'b0, dout}, 32'h0000_0022);
      applyStimulus(0, SW, 8'h00, 0, 1);

      // Idle cycles with garbage on the bus
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      applyStimulus(1, SR, 8'h05, 0, 1);
      applyStimulus(1, RD, 8'h00, 0, 1);
      applyStimulus(1, SR, 8'h00, 0, 1);
      applyStimulus(1, RD, 8'h00, 0, 1);
      applyStimulus(0, SW, 8'h00, 0, 1);

      // Asynchronous reset with a pending return word and a write in flight
      applyStimulus(1, SR, 8'h01, 0, 0);
      applyStimulus(1, RD, 8'h00, 0, 0);
      rx_valid = 1'b1;
      din      = {WR, 8'hEE};
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_tx_valid", {31'b0, tx_valid}, 32'd0);
      checkOutput("arst_dout",     {24'b0, dout},     32'd0);
      @(posedge clk);
      #1;
      checkOutput("arst_hold_tv", {31'b0, tx_valid}, 32'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, RD, 8'h00, 0, 1);
      checkOutput("arst_write_lost", {24'b0, dout}, 32'h0000_0033);
      applyStimulus(1, SR, 8'h05, 0, 1);
      applyStimulus(1, RD, 8'h00, 0, 1);
      checkOutput("arst_mem_kept", {24'b0, dout}, 32'h0000_00A5);
      applyStimulus(0, SW, 8'h00, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
